wb_bus_fabric: RTL and testbench

Parametrised single-master Wishbone B4 classic fabric between the core's `wishbone_controller` and the SoC peripherals (`data_mem`, instruction memory, `gpio_top`, `uart_top`, `clint_wishbone`, SPI flash). It replaces a fixed-slave interconnect:
- decodes into `NUM_SLAVES` windows set by base and mask parameters,
- registers the request and response paths,
- terminates unmapped and unresponsive accesses with an error instead of hanging the pipeline.

---
 rtl/wb_bus_fabric.sv | 211 +++++++++++++++++++++
 tb/tb_wb_bus_fabric.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_fabric.sv
// wb_bus_fabric: single-master Wishbone B4 classic fabric with NUM_SLAVES
// base/mask decode windows, registered request and response paths, and
// error termination of unmapped accesses and slave errors.
// Optional feature: define WB_FABRIC_TIMEOUT_EN to compile in the FWD
// watchdog (TIMEOUT_CYCLES, timeout_o); otherwise timeout_o is tied low.
module wb_bus_fabric #(
    parameter int unsigned                  NUM_SLAVES     = 6,
    parameter logic [32*NUM_SLAVES-1:0]     SLV_BASE       = {32'h6000_0000, 32'h5000_0000,
                                                              32'h4000_0000, 32'h3000_0000,
                                                              32'h2000_0000, 32'h0000_0000},
    parameter logic [32*NUM_SLAVES-1:0]     SLV_MASK       = {32'hFFFF_F000, 32'hFFFF_F000,
                                                              32'hFFFF_F000, 32'hFFFF_F000,
                                                              32'hFFFF_F000, 32'hFFFF_F000},
    parameter int unsigned                  TIMEOUT_CYCLES = 255
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [31:0]                wbm_adr_i,
    input  logic [31:0]                wbm_dat_i,
    input  logic [3:0]                 wbm_sel_i,
    input  logic                       wbm_we_i,
    input  logic                       wbm_cyc_i,
    input  logic                       wbm_stb_i,
    output logic [31:0]                wbm_dat_o,
    output logic                       wbm_ack_o,
    output logic                       wbm_err_o,
    output logic [32*NUM_SLAVES-1:0]   wbs_adr_o,
    output logic [32*NUM_SLAVES-1:0]   wbs_dat_o,
    output logic [4*NUM_SLAVES-1:0]    wbs_sel_o,
    output logic [NUM_SLAVES-1:0]      wbs_we_o,
    output logic [NUM_SLAVES-1:0]      wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]      wbs_stb_o,
    input  logic [32*NUM_SLAVES-1:0]   wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]      wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]      wbs_err_i,
    output logic                       timeout_o,
    output logic [31:0]                err_adr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_e;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    state_e                  state_q;
    logic [31:0]             adr_q;
    logic [31:0]             dat_q;
    logic [3:0]              sel_q;
    logic                    we_q;
    logic [NUM_SLAVES-1:0]   slv_q;     // one-hot selected slave
    logic [NUM_SLAVES-1:0]   cyc_q;     // drives both cyc and stb per slave
    logic                    ack_q;
    logic                    err_q;
    logic [31:0]             rdat_q;
    logic [31:0]             err_adr_q;

    logic [NUM_SLAVES-1:0]   match_s;
    logic [NUM_SLAVES-1:0]   slv_d;
    logic                    hit_s;
    logic [31:0]             sel_dat_s;
    logic                    sel_ack_s;
    logic                    sel_err_s;

`ifdef WB_FABRIC_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 32'd1);
    logic [15:0]             wd_cnt_q;
    logic                    timeout_q;
    logic                    wd_fire_s;

    // Fires in the FWD cycle that completes TIMEOUT_CYCLES of waiting.
    assign wd_fire_s = (wd_cnt_q == WD_LAST);
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    // Address decode: one match bit per window, checked on the live master address.
    always_comb begin
        match_s = {NUM_SLAVES{1'b0}};
        for (int i = 0; i < NUM_SLAVES; i++) begin
            match_s[i] = ((wbm_adr_i & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]);
        end
    end

    // Isolating the lowest set bit gives lowest-index priority on overlapping windows.
    assign slv_d = match_s & (~match_s + NUM_SLAVES'(1));
    assign hit_s = |match_s;

    // Response mux: only the selected slave's data is visible to the master.
    always_comb begin
        sel_dat_s = 32'h0000_0000;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_dat_s = sel_dat_s | (wbs_dat_i[32*i +: 32] & {32{slv_q[i]}});
        end
    end

    assign sel_ack_s = |(wbs_ack_i & slv_q);
    assign sel_err_s = |(wbs_err_i & slv_q);

    // Request/response FSM; all master and slave outputs come from these registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            adr_q     <= 32'h0000_0000;
            dat_q     <= 32'h0000_0000;
            sel_q     <= 4'h0;
            we_q      <= 1'b0;
            slv_q     <= {NUM_SLAVES{1'b0}};
            cyc_q     <= {NUM_SLAVES{1'b0}};
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdat_q    <= 32'h0000_0000;
            err_adr_q <= 32'h0000_0000;
`ifdef WB_FABRIC_TIMEOUT_EN
            wd_cnt_q  <= 16'h0000;
            timeout_q <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
`ifdef WB_FABRIC_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (wbm_cyc_i && wbm_stb_i) begin
                        adr_q <= wbm_adr_i;
                        dat_q <= wbm_dat_i;
                        sel_q <= wbm_sel_i;
                        we_q  <= wbm_we_i;
                        slv_q <= slv_d;
                        if (hit_s) begin
                            cyc_q   <= slv_d;
                            state_q <= FWD;
`ifdef WB_FABRIC_TIMEOUT_EN
                            wd_cnt_q <= 16'h0000;
`endif
                        end else begin
                            state_q <= ERR;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                FWD: begin
                    if (!wbm_cyc_i) begin
                        // Master abandoned the cycle: release the slave silently.
                        cyc_q   <= {NUM_SLAVES{1'b0}};
                        state_q <= IDLE;
                    end else if (sel_err_s) begin
                        // Error takes priority over a simultaneous ack.
                        cyc_q     <= {NUM_SLAVES{1'b0}};
                        err_q     <= 1'b1;
                        rdat_q    <= sel_dat_s;
                        err_adr_q <= adr_q;
                        state_q   <= RESP;
                    end else if (sel_ack_s) begin
                        cyc_q   <= {NUM_SLAVES{1'b0}};
                        ack_q   <= 1'b1;
                        rdat_q  <= sel_dat_s;
                        state_q <= RESP;
`ifdef WB_FABRIC_TIMEOUT_EN
                    end else if (wd_fire_s) begin
                        cyc_q     <= {NUM_SLAVES{1'b0}};
                        err_q     <= 1'b1;
                        timeout_q <= 1'b1;
                        rdat_q    <= ERR_DATA;
                        err_adr_q <= adr_q;
                        state_q   <= RESP;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 16'd1;
                    end
`else
                    end else begin
                        state_q <= FWD;
                    end
`endif
                end
                ERR: begin
                    err_q     <= 1'b1;
                    rdat_q    <= ERR_DATA;
                    err_adr_q <= adr_q;
                    state_q   <= RESP;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    cyc_q   <= {NUM_SLAVES{1'b0}};
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wbm_dat_o = rdat_q;
    assign wbm_ack_o = ack_q;
    assign wbm_err_o = err_q;
    assign err_adr_o = err_adr_q;
    assign wbs_adr_o = {NUM_SLAVES{adr_q}};
    assign wbs_dat_o = {NUM_SLAVES{dat_q}};
    assign wbs_sel_o = {NUM_SLAVES{sel_q}};
    assign wbs_we_o  = {NUM_SLAVES{we_q}};
    assign wbs_cyc_o = cyc_q;
    assign wbs_stb_o = cyc_q;

endmodule

// File: tb/tb_wb_bus_fabric.sv
// Directed testbench for wb_bus_fabric: behavioural slaves with per-slave
// latency and response mode, hand-computed expected values per vector.
`timescale 1ns/1ps
module tb_wb_bus_fabric;

    localparam int NS       = 6;
    localparam int MAX_WAIT = 40;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       m_adr, m_dat;
    logic [3:0]        m_sel;
    logic              m_we, m_cyc, m_stb;
    logic [31:0]       wbm_dat_o, err_adr_o;
    logic              wbm_ack_o, wbm_err_o, timeout_o;
    logic [32*NS-1:0]  wbs_adr_o, wbs_dat_o, wbs_dat_i;
    logic [4*NS-1:0]   wbs_sel_o;
    logic [NS-1:0]     wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_ack_i, wbs_err_i;

    always #5 clk = ~clk;

    wb_bus_fabric #(
        .NUM_SLAVES     (NS),
        .SLV_BASE       ({32'h5000_0000, 32'h5000_0000, 32'h4000_0000,
                          32'h3000_0000, 32'h2000_0000, 32'h0000_0000}),
        .SLV_MASK       ({32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_F000,
                          32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_F000}),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .wb_clk_i  (clk),       .wb_rst_i  (rst),
        .wbm_adr_i (m_adr),     .wbm_dat_i (m_dat),     .wbm_sel_i (m_sel),
        .wbm_we_i  (m_we),      .wbm_cyc_i (m_cyc),     .wbm_stb_i (m_stb),
        .wbm_dat_o (wbm_dat_o), .wbm_ack_o (wbm_ack_o), .wbm_err_o (wbm_err_o),
        .wbs_adr_o (wbs_adr_o), .wbs_dat_o (wbs_dat_o), .wbs_sel_o (wbs_sel_o),
        .wbs_we_o  (wbs_we_o),  .wbs_cyc_o (wbs_cyc_o), .wbs_stb_o (wbs_stb_o),
        .wbs_dat_i (wbs_dat_i), .wbs_ack_i (wbs_ack_i), .wbs_err_i (wbs_err_i),
        .timeout_o (timeout_o), .err_adr_o (err_adr_o)
    );

    // Slave models: mode 0 ack, 1 err, 2 ack+err, 3 never respond.
    int          lat_cfg  [NS];
    logic [1:0]  mode_cfg [NS];
    logic [31:0] rdat_cfg [NS];
    int          wcnt     [NS];
    logic [NS-1:0] spur;   // spurious ack/err on non-selected slaves

    // Counts how many cycles each slave's stb has been high.
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            wcnt[i] <= wbs_stb_o[i] ? wcnt[i] + 1 : 0;
        end
    end

    // Slave response generation.
    always_comb begin
        wbs_ack_i = spur;
        wbs_err_i = spur;
        wbs_dat_i = '0;
        for (int i = 0; i < NS; i++) begin
            wbs_dat_i[32*i +: 32] = rdat_cfg[i];
            if (wbs_cyc_o[i] && wbs_stb_o[i] && wcnt[i] == lat_cfg[i]) begin
                if (mode_cfg[i] == 2'd0 || mode_cfg[i] == 2'd2) wbs_ack_i[i] = 1'b1;
                if (mode_cfg[i] == 2'd1 || mode_cfg[i] == 2'd2) wbs_err_i[i] = 1'b1;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    logic [NS-1:0]    stb_or, cyc_or;
    int               stb_cyc, to_cnt;
    logic             unstable;
    logic [32*NS-1:0] snap_adr, snap_dat;
    logic [4*NS-1:0]  snap_sel;
    logic [NS-1:0]    snap_we;

    // Per-cycle monitor of slave-side activity during a transfer.
    task automatic sample();
        stb_or = stb_or | wbs_stb_o;
        cyc_or = cyc_or | wbs_cyc_o;
        to_cnt = to_cnt + int'(timeout_o);
        if (wbs_stb_o != '0) begin
            if (stb_cyc == 0) begin
                snap_adr = wbs_adr_o; snap_dat = wbs_dat_o;
                snap_sel = wbs_sel_o; snap_we  = wbs_we_o;
            end else if (snap_adr != wbs_adr_o || snap_dat != wbs_dat_o ||
                         snap_sel != wbs_sel_o || snap_we != wbs_we_o) begin
                unstable = 1'b1;
            end
            stb_cyc++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ack"},    32'(wbm_ack_o), 32'd0);
        check_val({tag, "_err"},    32'(wbm_err_o), 32'd0);
        check_val({tag, "_dat"},    wbm_dat_o, 32'd0);
        check_val({tag, "_erradr"}, err_adr_o, 32'd0);
        check_val({tag, "_tmo"},    32'(timeout_o), 32'd0);
        check_val({tag, "_cyc"},    32'(wbs_cyc_o), 32'd0);
        check_val({tag, "_stb"},    32'(wbs_stb_o), 32'd0);
        check_val({tag, "_sadr"},   32'(wbs_adr_o != '0), 32'd0);
        check_val({tag, "_sdat"},   32'(wbs_dat_o != '0), 32'd0);
        check_val({tag, "_ssel"},   32'(wbs_sel_o), 32'd0);
        check_val({tag, "_swe"},    32'(wbs_we_o), 32'd0);
    endtask

    task automatic run_vec(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic we, input int exp_lat,
                           input logic exp_ack, input logic exp_err, input logic chk_rd,
                           input logic [31:0] exp_rd, input logic [NS-1:0] exp_stb,
                           input int exp_stbcyc, input int exp_to);
        int          lat_seen;
        logic        got_ack, got_err, after;
        logic [31:0] rd;
        lat_seen = 0; got_ack = 1'b0; got_err = 1'b0; rd = 32'd0;
        stb_or = '0; cyc_or = '0; stb_cyc = 0; to_cnt = 0; unstable = 1'b0;
        @(posedge clk); #1;
        m_adr = adr; m_dat = dat; m_sel = sel; m_we = we; m_cyc = 1'b1; m_stb = 1'b1;
        for (int c = 1; c <= MAX_WAIT && lat_seen == 0; c++) begin
            @(posedge clk); @(negedge clk);
            sample();
            if (wbm_ack_o || wbm_err_o) begin
                lat_seen = c; got_ack = wbm_ack_o; got_err = wbm_err_o; rd = wbm_dat_o;
            end
        end
        @(posedge clk); #1;
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        @(negedge clk);
        sample();
        after = wbm_ack_o | wbm_err_o;
        check_val({tag, "_lat"},     32'(lat_seen), 32'(exp_lat));
        check_val({tag, "_ack"},     32'(got_ack), 32'(exp_ack));
        check_val({tag, "_err"},     32'(got_err), 32'(exp_err));
        check_val({tag, "_pulse"},   32'(after), 32'd0);
        check_val({tag, "_stbset"},  32'(stb_or), 32'(exp_stb));
        check_val({tag, "_cycset"},  32'(cyc_or), 32'(exp_stb));
        check_val({tag, "_stbcyc"},  32'(stb_cyc), 32'(exp_stbcyc));
        check_val({tag, "_stable"},  32'(unstable), 32'd0);
        check_val({tag, "_tmocnt"},  32'(to_cnt), 32'(exp_to));
        if (chk_rd) check_val({tag, "_rdat"}, rd, exp_rd);
        if (exp_err) check_val({tag, "_erradr"}, err_adr_o, adr);
    endtask

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish, expected finish before time limit");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic resp_seen;
        for (int i = 0; i < NS; i++) begin
            lat_cfg[i] = 0; mode_cfg[i] = 2'd0; rdat_cfg[i] = 32'hC0DE_0000 + 32'(i);
        end
        rdat_cfg[1] = 32'h1234_5678;
        spur = '0;
        m_adr = 32'd0; m_dat = 32'd0; m_sel = 4'd0; m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst0");
        @(posedge clk); #1; rst = 1'b0;

        // Read slave 1, immediate ack: response in cycle 2.
        run_vec("rd_s1", 32'h2000_0010, 32'd0, 4'hF, 1'b0, 2, 1'b1, 1'b0, 1'b1,
                32'h1234_5678, 6'b000010, 1, 0);

        // Write slave 3, ack in 5th stb cycle, with spurious ack/err on slaves 0 and 5.
        lat_cfg[3] = 4; spur = 6'b100001;
        run_vec("wr_s3", 32'h4000_0040, 32'hA5A5_A5A5, 4'b0011, 1'b1, 6, 1'b1, 1'b0, 1'b0,
                32'd0, 6'b001000, 5, 0);
        spur = '0;
        check_val("wr_s3_sadr", snap_adr[3*32 +: 32], 32'h4000_0040);
        check_val("wr_s3_sdat", snap_dat[3*32 +: 32], 32'hA5A5_A5A5);
        check_val("wr_s3_ssel", 32'(snap_sel[3*4 +: 4]), 32'h3);
        check_val("wr_s3_swe",  32'(snap_we[3]), 32'd1);

        // Unmapped address and window edges.
        run_vec("unmap", 32'h7000_0000, 32'd0, 4'hF, 1'b0, 2, 1'b0, 1'b1, 1'b1,
                32'hDEAD_BEEF, 6'b000000, 0, 0);
        run_vec("edge_hit", 32'h2000_FFFC, 32'd0, 4'hF, 1'b0, 2, 1'b1, 1'b0, 1'b1,
                32'h1234_5678, 6'b000010, 1, 0);
        run_vec("edge_miss", 32'h2001_0000, 32'd0, 4'hF, 1'b0, 2, 1'b0, 1'b1, 1'b1,
                32'hDEAD_BEEF, 6'b000000, 0, 0);

        // Overlapping windows 4 and 5: lowest index wins where both match.
        lat_cfg[4] = 1;
        run_vec("ovl_s4", 32'h5000_0100, 32'd0, 4'hF, 1'b0, 3, 1'b1, 1'b0, 1'b1,
                32'hC0DE_0004, 6'b010000, 2, 0);
        run_vec("ovl_s5", 32'h5001_0000, 32'd0, 4'hF, 1'b0, 2, 1'b1, 1'b0, 1'b1,
                32'hC0DE_0005, 6'b100000, 1, 0);

        // Slave error paths: ack+err together, then err alone.
        mode_cfg[2] = 2'd2;
        run_vec("ackerr", 32'h3000_0008, 32'd0, 4'hF, 1'b0, 2, 1'b0, 1'b1, 1'b0,
                32'd0, 6'b000100, 1, 0);
        mode_cfg[2] = 2'd0;
        lat_cfg[4] = 0; mode_cfg[4] = 2'd1;
        run_vec("slverr", 32'h5000_0200, 32'd0, 4'hF, 1'b0, 2, 1'b0, 1'b1, 1'b0,
                32'd0, 6'b010000, 1, 0);
        mode_cfg[4] = 2'd0;

        // Unresponsive slave 0.
        mode_cfg[0] = 2'd3;
`ifdef WB_FABRIC_TIMEOUT_EN
        run_vec("tmo", 32'h0000_0100, 32'd0, 4'hF, 1'b0, 9, 1'b0, 1'b1, 1'b0,
                32'd0, 6'b000001, 8, 1);
`else
        run_vec("nowd", 32'h0000_0100, 32'd0, 4'hF, 1'b0, 0, 1'b0, 1'b0, 1'b0,
                32'd0, 6'b000001, MAX_WAIT + 1, 0);
`endif
        mode_cfg[0] = 2'd0;
        run_vec("after_hang", 32'h2000_0020, 32'd0, 4'hF, 1'b0, 2, 1'b1, 1'b0, 1'b1,
                32'h1234_5678, 6'b000010, 1, 0);

        // Abort: master drops cyc while slave 2 is still waiting.
        lat_cfg[2] = 20;
        @(posedge clk); #1;
        m_adr = 32'h3000_0008; m_we = 1'b0; m_sel = 4'hF; m_cyc = 1'b1; m_stb = 1'b1;
        @(posedge clk); @(negedge clk);
        check_val("abt_stb1", 32'(wbs_stb_o), 32'b000100);
        @(posedge clk); #1;
        m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge clk);
        check_val("abt_hold", 32'(wbs_stb_o), 32'b000100);
        @(posedge clk); @(negedge clk);
        check_val("abt_cyc", 32'(wbs_cyc_o), 32'd0);
        check_val("abt_stb", 32'(wbs_stb_o), 32'd0);
        resp_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            resp_seen = resp_seen | wbm_ack_o | wbm_err_o;
        end
        check_val("abt_noresp", 32'(resp_seen), 32'd0);
        run_vec("after_abt", 32'h2000_0030, 32'd0, 4'hF, 1'b0, 2, 1'b1, 1'b0, 1'b1,
                32'h1234_5678, 6'b000010, 1, 0);

        // Reset in FWD: everything returns to zero, no response afterwards.
        lat_cfg[3] = 20;
        @(posedge clk); #1;
        m_adr = 32'h4000_0080; m_dat = 32'h5555_AAAA; m_sel = 4'hF; m_we = 1'b1;
        m_cyc = 1'b1; m_stb = 1'b1;
        @(posedge clk); @(negedge clk);
        check_val("rstf_stb", 32'(wbs_stb_o), 32'b001000);
        @(posedge clk); #1;
        rst = 1'b1; m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        @(posedge clk); @(negedge clk);
        check_all_zero("rstf");
        @(posedge clk); #1; rst = 1'b0;
        resp_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            resp_seen = resp_seen | wbm_ack_o | wbm_err_o | (|wbs_cyc_o);
        end
        check_val("rstf_quiet", 32'(resp_seen), 32'd0);
        run_vec("after_rst", 32'h2000_0040, 32'd0, 4'hF, 1'b0, 2, 1'b1, 1'b0, 1'b1,
                32'h1234_5678, 6'b000010, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
